mem_access: RTL
===============

MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 SHALL have parameter TIMEOUT, default 15: maximum BUSY cycles awaiting mem_ready before abort (legal range 2..255).
REQ-002 SHALL have port clk, input, 1: sole clock; all state changes on rising edge.
REQ-003 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-004 SHALL have port addr, input, 16: effective address from execute-stage ALU result.
REQ-005 SHALL have port wrData, input, 16: store data from execute stage.
REQ-006 SHALL have port memRead, input, 1: load request.
REQ-007 SHALL have port memWrite, input, 1: store request.
REQ-008 SHALL have port stall, output, 1: holds pipeline while an access is in flight.
REQ-009 SHALL have port done, output, 1: one-cycle completion pulse.
REQ-010 SHALL have port rdData, output, 16: last completed load data.
REQ-011 SHALL have port err, output, 1: error pulse, coincident with done.
REQ-012 SHALL have port err_code, output, 2: 00 none, 01 unaligned, 10 read/write conflict, 11 timeout.
REQ-013 SHALL have port mem_en, output, 1: memory request valid.
REQ-014 SHALL have port mem_wr, output, 1: 1 = write, 0 = read; meaningful only with mem_en.
REQ-015 SHALL have port mem_addr, output, 16: latched word address.
REQ-016 SHALL have port mem_wdata, output, 16: latched store data.
REQ-017 SHALL have port mem_rdata, input, 16: memory read data, valid with mem_ready.
REQ-018 SHALL have port mem_ready, input, 1: memory completion, sampled only in BUSY.

Function
REQ-019 SHALL implement FSM states IDLE, BUSY, DONE; the state register resets to IDLE.
REQ-020 In IDLE, req = memRead | memWrite; when req=0, stall=0 and the state stays IDLE.
REQ-021 In IDLE with req=1: stall SHALL be 1 combinationally in the same cycle.
REQ-022 In IDLE with memRead=1 and memWrite=1: no memory access; the next state SHALL be DONE with err_code=10.
REQ-023 In IDLE with a single op and addr[0]=1: no memory access; the next state SHALL be DONE with err_code=01; conflict (10) takes priority over unaligned (01).
REQ-024 In IDLE with a legal request: addr, wrData, and op SHALL be latched; the wait counter SHALL clear to 0; the next state SHALL be BUSY.
REQ-025 In BUSY: mem_en=1, mem_wr=latched op, mem_addr and mem_wdata=latched values, stall=1; addr, wrData, memRead, and memWrite SHALL be ignored.
REQ-026 In BUSY with mem_ready=1 at the edge: a read SHALL load mem_rdata into rdData; the next state SHALL be DONE with err_code=00.
REQ-027 In BUSY with mem_ready=0: the counter SHALL increment; if the counter equals TIMEOUT-1, the next state SHALL be DONE with err_code=11 and rdData unchanged.
REQ-028 mem_ready in the same cycle as timeout expiry SHALL win: normal completion, no error.
REQ-029 In DONE: stall=0, done=1, err=(err_code!=00); mem_en=0; request inputs SHALL be ignored; the next state SHALL always be IDLE.
REQ-030 err_code SHALL hold its value from DONE until the next DONE; err and done SHALL be single-cycle pulses.
REQ-031 rdData SHALL change only on a successful read completion; writes and errors SHALL leave it unchanged.
REQ-032 Outside BUSY, mem_en=0, and mem_wr, mem_addr, and mem_wdata SHALL hold their last latched values.
REQ-033 Minimum legal access latency SHALL be 3 cycles (IDLE-request, BUSY, DONE); stall is high for exactly 2 of these cycles.
REQ-034 Back-to-back requests SHALL be accepted no sooner than the cycle after DONE.

Reset
REQ-035 rst=1 SHALL force, asynchronously, state=IDLE, counter=0, stall=0 (absent request), done=0, err=0, err_code=00, rdData=0x0000, mem_en=0, mem_wr=0, mem_addr=0x0000, mem_wdata=0x0000.
REQ-036 rst asserted in BUSY SHALL drop mem_en in that same cycle; no done pulse SHALL follow; the aborted access SHALL leave no residual state.

Verification
REQ-037 Read: memRead=1, addr=0x0010; mem_ready=1 first BUSY cycle with mem_rdata=0xBEEF -> stall 1,1,0; done at cycle 2; rdData=0xBEEF; err=0.
REQ-038 Write: memWrite=1, addr=0x0020, wrData=0x1234; mem_ready after 3 BUSY cycles -> mem_en=1 with mem_wr=1, mem_addr=0x0020, mem_wdata=0x1234 for 3 cycles; done; rdData unchanged.
REQ-039 Unaligned: memRead=1, addr=0x0011 -> mem_en never 1; next cycle done=1, err=1, err_code=01.
REQ-040 Conflict: memRead=memWrite=1, addr=0x0013 -> done=1, err_code=10 (not 01), no memory access.
REQ-041 Timeout: TIMEOUT=15, mem_ready held 0 -> exactly 15 BUSY cycles, then done=1, err_code=11; repeat with mem_ready=1 on the 15th BUSY cycle -> err_code=00.
REQ-042 Reset mid-access: rst pulsed in 2nd BUSY cycle -> mem_en=0 immediately; all outputs at reset values; a subsequent legal read completes normally.

Source files
------------

// File: rtl/mem_access.sv
// mem_access: load/store sequencer between the execute stage and a
// ready/valid style data memory. A legal request is latched and held on the
// memory bus until mem_ready or until the wait budget runs out; illegal
// requests (conflicting or unaligned) complete immediately with an error.
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | no access in flight; a request is decoded and checked here
// BUSY  | latched access presented on the memory bus, waiting for mem_ready
// DONE  | one-cycle completion: done pulses, err pulses on a nonzero code
module mem_access #(
   parameter int unsigned TIMEOUT = 15
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] addr,
   input  logic [15:0] wrData,
   input  logic        memRead,
   input  logic        memWrite,
   output logic        stall,
   output logic        done,
   output logic [15:0] rdData,
   output logic        err,
   output logic [1:0]  err_code,
   output logic        mem_en,
   output logic        mem_wr,
   output logic [15:0] mem_addr,
   output logic [15:0] mem_wdata,
   input  logic [15:0] mem_rdata,
   input  logic        mem_ready
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam logic [1:0] ERR_NONE     = 2'b00;
   localparam logic [1:0] ERR_UNALIGN  = 2'b01;
   localparam logic [1:0] ERR_CONFLICT = 2'b10;
   localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

   // last wait-counter value before the access is abandoned
   localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

   state_t      state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [1:0]  code_q, code_d;
   logic [15:0] rd_q, rd_d;
   logic        wr_q, wr_d;
   logic [15:0] addr_q, addr_d;
   logic [15:0] wdata_q, wdata_d;
   logic        req;

   assign req = memRead | memWrite;

   // next-state and latch decisions for the access sequencer
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      code_d  = code_q;
      rd_d    = rd_q;
      wr_d    = wr_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      case (state_q)
         S_IDLE: begin
            if (req) begin
               if (memRead && memWrite) begin
                  code_d  = ERR_CONFLICT;
                  state_d = S_DONE;
               end else if (addr[0]) begin
                  code_d  = ERR_UNALIGN;
                  state_d = S_DONE;
               end else begin
                  wr_d    = memWrite;
                  addr_d  = addr;
                  wdata_d = wrData;
                  cnt_d   = 8'd0;
                  state_d = S_BUSY;
               end
            end
         end
         S_BUSY: begin
            // a ready arriving on the last allowed cycle still completes
            if (mem_ready) begin
               if (!wr_q) begin
                  rd_d = mem_rdata;
               end
               code_d  = ERR_NONE;
               state_d = S_DONE;
            end else if (cnt_q == CNT_LAST) begin
               code_d  = ERR_TIMEOUT;
               state_d = S_DONE;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // state and latched access registers, cleared asynchronously by rst
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= 8'd0;
         code_q  <= ERR_NONE;
         rd_q    <= 16'h0000;
         wr_q    <= 1'b0;
         addr_q  <= 16'h0000;
         wdata_q <= 16'h0000;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         code_q  <= code_d;
         rd_q    <= rd_d;
         wr_q    <= wr_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
      end
   end

   // stall must rise in the request cycle itself, hence the req term
   assign stall     = (state_q == S_BUSY) || ((state_q == S_IDLE) && req);
   assign done      = (state_q == S_DONE);
   assign err       = (state_q == S_DONE) && (code_q != ERR_NONE);
   assign err_code  = code_q;
   assign rdData    = rd_q;
   assign mem_en    = (state_q == S_BUSY);
   assign mem_wr    = wr_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;

endmodule
